// File: rtl/ahbl_cmd_master.sv
// AHB-Lite command master: one queued command becomes SINGLE/INCR transfers.
// Write beats are pulled from a local source, read beats pushed to a sink.
module ahbl_cmd_master #(
  parameter int AHB_AWIDTH = 32,
  parameter int AHB_DWIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [AHB_AWIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [4:0]            cmd_len,
  output logic                  wdata_rd,
  input  logic [AHB_DWIDTH-1:0] wdata,
  output logic                  rdata_valid,
  output logic [AHB_DWIDTH-1:0] rdata,
  output logic                  done,
  output logic                  err,
  output logic [AHB_AWIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [AHB_DWIDTH-1:0] HWDATA,
  input  logic [AHB_DWIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic [1:0]            HRESP
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_LAST,
    S_ERR2
  } state_t;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [1:0] R_OKAY = 2'b00;
  localparam logic [1:0] R_ERR  = 2'b01;

  state_t                  state_q, state_d;
  logic [AHB_AWIDTH-1:0]   haddr_q, haddr_d;
  logic [1:0]              htrans_q, htrans_d;
  logic                    hwrite_q, hwrite_d;
  logic [2:0]              hsize_q, hsize_d;
  logic [2:0]              hburst_q, hburst_d;
  logic [4:0]              beats_q, beats_d;
  logic                    dph_q, dph_d;
  logic [AHB_DWIDTH-1:0]   rdata_q, rdata_d;
  logic                    rvld_q, rvld_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [AHB_AWIDTH-1:0]   nxt_addr;
  logic                    addr_ok;
  logic                    bad_cmd;
  logic                    dp_err;
  logic                    rd_ok;

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    hburst_d = hburst_q;
    beats_d  = beats_q;
    dph_d    = dph_q;
    rdata_d  = rdata_q;
    rvld_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (cmd_size)
      3'd0:    addr_ok = 1'b1;
      3'd1:    addr_ok = ~cmd_addr[0];
      3'd2:    addr_ok = (cmd_addr[1:0] == 2'b00);
      default: addr_ok = 1'b0;
    endcase
    bad_cmd = ~addr_ok
            | (cmd_len == 5'd0)
            | (cmd_len > 5'd16);

    nxt_addr = haddr_q + (AHB_AWIDTH'(1) << hsize_q);
    dp_err   = (HRESP == R_ERR) & ~HREADY;
    rd_ok    = HREADY & (HRESP == R_OKAY) & ~hwrite_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (bad_cmd) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            haddr_d  = cmd_addr;
            htrans_d = T_NSEQ;
            hwrite_d = cmd_write;
            hsize_d  = cmd_size;
            hburst_d = (cmd_len == 5'd1) ? 3'b000 : 3'b001;
            beats_d  = cmd_len - 5'd1;
            dph_d    = 1'b0;
            state_d  = S_XFER;
          end
        end
      end
      S_XFER: begin
        if (dph_q && dp_err) begin
          htrans_d = T_IDLE;
          state_d  = S_ERR2;
        end else if (HREADY) begin
          if (dph_q && rd_ok) begin
            rdata_d = HRDATA;
            rvld_d  = 1'b1;
          end
          dph_d = 1'b1;
          if (beats_q != 5'd0) begin
            haddr_d  = nxt_addr;
            // a 1KB boundary restarts the burst
            htrans_d = (nxt_addr[9:0] == 10'd0) ? T_NSEQ : T_SEQ;
            beats_d  = beats_q - 5'd1;
          end else begin
            htrans_d = T_IDLE;
            state_d  = S_LAST;
          end
        end
      end
      S_LAST: begin
        if (dp_err) begin
          state_d = S_ERR2;
        end else if (HREADY) begin
          if (rd_ok) begin
            rdata_d = HRDATA;
            rvld_d  = 1'b1;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR2: begin
        if (HREADY) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q  <= S_IDLE;
      haddr_q  <= '0;
      htrans_q <= T_IDLE;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'd0;
      hburst_q <= 3'd0;
      beats_q  <= 5'd0;
      dph_q    <= 1'b0;
      rdata_q  <= '0;
      rvld_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      hburst_q <= hburst_d;
      beats_q  <= beats_d;
      dph_q    <= dph_d;
      rdata_q  <= rdata_d;
      rvld_q   <= rvld_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign wdata_rd    = (state_q == S_XFER) & htrans_q[1]
                     & HREADY & hwrite_q;
  assign rdata_valid = rvld_q;
  assign rdata       = rdata_q;
  assign done        = done_q;
  assign err         = err_q;
  assign HADDR       = haddr_q;
  assign HTRANS      = htrans_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = hsize_q;
  assign HBURST      = hburst_q;
  assign HWDATA      = wdata;

endmodule

// File: tb/tb_ahbl_cmd_master.sv
// Bench for ahbl_cmd_master: reactive AHB slave model plus
// scoreboard queues for address beats, write data, read data and done.
module tb_ahbl_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETN = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [2:0]  cmd_size = 3'd0;
  logic [4:0]  cmd_len = 5'd0;
  logic        wdata_rd;
  logic [31:0] wdata = 32'h0;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  ahbl_cmd_master #(.AHB_AWIDTH(32), .AHB_DWIDTH(32)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wdata_rd(wdata_rd), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata),
    .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  t;
    logic [2:0]  s;
    logic        w;
    logic [2:0]  b;
  } beat_t;

  beat_t       exp_addr[$];
  logic [31:0] exp_wd[$];
  logic [31:0] exp_rd[$];
  logic        exp_done[$];
  logic [31:0] src_q[$];

  int n_chk = 0;
  int n_err = 0;
  int pops = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  int ws_beat = -1;
  int ws_n = 0;
  int err_beat = -1;
  logic        dp_valid, dp_write, dp_err, ecyc;
  logic [31:0] dp_addr;
  int          wcnt, beat_cnt;

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 2'b00;
    if (dp_valid && dp_err) begin
      HREADY = ecyc;
      HRESP  = 2'b01;
    end else if (dp_valid) begin
      HREADY = (wcnt == 0);
    end
    HRDATA = (dp_valid && !dp_write) ? pat(dp_addr) : 32'h0;
  end

  always @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_err   <= 1'b0;
      dp_addr  <= 32'h0;
      ecyc     <= 1'b0;
      wcnt     <= 0;
      beat_cnt <= 0;
    end else if (dp_valid && !HREADY) begin
      if (dp_err) ecyc <= 1'b1;
      else wcnt <= wcnt - 1;
    end else begin
      dp_valid <= HTRANS[1];
      if (HTRANS[1]) begin
        dp_addr  <= HADDR;
        dp_write <= HWRITE;
        dp_err   <= (beat_cnt == err_beat);
        wcnt     <= (beat_cnt == ws_beat) ? ws_n : 0;
        ecyc     <= 1'b0;
        beat_cnt <= beat_cnt + 1;
      end else if (done) begin
        beat_cnt <= 0;
      end
    end
  end

  logic [31:0] w_nx;
  always @(posedge HCLK) begin
    if (wdata_rd && src_q.size() > 0) begin
      w_nx = src_q.pop_front();
      wdata <= w_nx;
    end
  end

  logic  e1 = 1'b0;
  beat_t mb;
  logic [31:0] mw;
  logic        me;
  always @(negedge HCLK) begin
    if (HRESETN) begin
      if (e1) chk("err_idle", 32'(HTRANS), 32'd0);
      e1 = dp_valid && dp_err && !ecyc;
      if (HTRANS[1] && HREADY) begin
        if (exp_addr.size() == 0) begin
          chk("addr_spur", 32'd1, 32'd0);
        end else begin
          mb = exp_addr.pop_front();
          chk("haddr", HADDR, mb.a);
          chk("htrans", 32'(HTRANS), 32'(mb.t));
          chk("hsize", 32'(HSIZE), 32'(mb.s));
          chk("hwrite", 32'(HWRITE), 32'(mb.w));
          chk("hburst", 32'(HBURST), 32'(mb.b));
          chk("wdata_rd", 32'(wdata_rd), 32'(mb.w));
        end
      end
      if (wdata_rd) pops++;
      if (dp_valid && dp_write && !dp_err && HREADY) begin
        if (exp_wd.size() == 0) begin
          chk("hwdata_spur", 32'd1, 32'd0);
        end else begin
          mw = exp_wd.pop_front();
          chk("hwdata", HWDATA, mw);
        end
      end
      if (rdata_valid) begin
        if (exp_rd.size() == 0) begin
          chk("rdata_spur", 32'd1, 32'd0);
        end else begin
          mw = exp_rd.pop_front();
          chk("rdata", rdata, mw);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          chk("done_spur", 32'd1, 32'd0);
        end else begin
          me = exp_done.pop_front();
          chk("err", 32'(err), 32'(me));
        end
      end
    end else begin
      e1 = 1'b0;
    end
  end

  task automatic chk_rst();
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hsize", 32'(HSIZE), 32'd0);
    chk("rst_hburst", 32'(HBURST), 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_wrd", 32'(wdata_rd), 32'd0);
    chk("rst_rvld", 32'(rdata_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
  endtask

  task automatic push_beat(input logic [31:0] a, input int i,
                           input logic [2:0] sz, input logic w,
                           input logic [4:0] ln);
    beat_t bt;
    bt.a = a;
    bt.t = (i == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11;
    bt.s = sz;
    bt.w = w;
    bt.b = (ln == 5'd1) ? 3'b000 : 3'b001;
    exp_addr.push_back(bt);
  endtask

  task automatic run_cmd(input logic w, input logic [31:0] a,
                         input logic [2:0] sz, input logic [4:0] ln,
                         input int wsb, input int wsn, input int eb,
                         input logic [31:0] wd0);
    bit          bad, erq;
    int          n_a, n_d, lat, cyc, p0, k;
    logic [31:0] ad;
    bad = (sz > 3'd2) || (ln == 5'd0) || (ln > 5'd16)
        || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
    erq = !bad && eb >= 0 && eb < int'(ln);
    ws_beat = wsb;
    ws_n = wsn;
    err_beat = eb;
    n_a = bad ? 0 : (erq ? eb + 1 : int'(ln));
    n_d = bad ? 0 : (erq ? eb : int'(ln));
    for (int i = 0; i < n_a; i++) begin
      ad = a + ((32'd1 << sz) * i);
      push_beat(ad, i, sz, w, ln);
      if (w) src_q.push_back(wd0 + i);
      if (i < n_d) begin
        if (w) exp_wd.push_back(wd0 + i);
        else exp_rd.push_back(pat(ad));
      end
    end
    exp_done.push_back(bad || erq);
    if (bad) lat = 1;
    else if (erq) lat = eb + 4;
    else lat = int'(ln) + 2 + ((wsb >= 0 && wsb < int'(ln)) ? wsn : 0);
    p0 = pops;
    cmd_write = w;
    cmd_addr = a;
    cmd_size = sz;
    cmd_len = ln;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge HCLK);
      #1;
      k++;
    end
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge HCLK);
    #1 cmd_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge HCLK);
      cyc++;
    end while (!done && cyc < 300);
    #1;
    chk("latency", 32'(cyc), 32'(lat));
    chk("pops", 32'(pops - p0), w ? 32'(n_a) : 32'd0);
    chk("addr_left", 32'(exp_addr.size()), 32'd0);
    chk("wd_left", 32'(exp_wd.size()), 32'd0);
    chk("rd_left", 32'(exp_rd.size()), 32'd0);
    chk("done_left", 32'(exp_done.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge HCLK);
    chk_rst();
    HRESETN = 1'b1;
    repeat (2) @(negedge HCLK);
    #1;
    run_cmd(1'b1, 32'h100, 3'd2, 5'd1, -1, 0, -1, 32'hDEADBEEF);
    run_cmd(1'b0, 32'h200, 3'd2, 5'd4, 1, 2, -1, 32'h0);
    run_cmd(1'b1, 32'h3F8, 3'd2, 5'd8, -1, 0, -1, 32'h1000_0000);
    run_cmd(1'b0, 32'h600, 3'd2, 5'd6, -1, 0, 2, 32'h0);
    run_cmd(1'b0, 32'h200, 3'd3, 5'd2, -1, 0, -1, 32'h0);
    run_cmd(1'b1, 32'h102, 3'd2, 5'd1, -1, 0, -1, 32'h0);
    run_cmd(1'b0, 32'h200, 3'd2, 5'd0, -1, 0, -1, 32'h0);
    run_cmd(1'b0, 32'h301, 3'd0, 5'd3, -1, 0, -1, 32'h0);
    run_cmd(1'b1, 32'h502, 3'd1, 5'd2, 0, 1, -1, 32'h7700_0000);

    ws_beat = -1;
    err_beat = -1;
    for (int i = 0; i < 16; i++) begin
      push_beat(32'h800 + 32'(i * 4), i, 3'd2, 1'b1, 5'd16);
      src_q.push_back(32'h8000_0000 + 32'(i));
      exp_wd.push_back(32'h8000_0000 + 32'(i));
    end
    cmd_write = 1'b1;
    cmd_addr = 32'h800;
    cmd_size = 3'd2;
    cmd_len = 5'd16;
    cmd_valid = 1'b1;
    @(posedge HCLK);
    #1 cmd_valid = 1'b0;
    repeat (5) @(negedge HCLK);
    chk("mid_busy", 32'(HTRANS[1]), 32'd1);
    #2 HRESETN = 1'b0;
    #1 chk_rst();
    exp_addr.delete();
    exp_wd.delete();
    src_q.delete();
    repeat (2) @(negedge HCLK);
    HRESETN = 1'b1;
    #1;
    run_cmd(1'b0, 32'h200, 3'd2, 5'd2, -1, 0, -1, 32'h0);
    run_cmd(1'b1, 32'h900, 3'd2, 5'd3, -1, 0, -1, 32'h4400_0000);
    repeat (3) @(negedge HCLK);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
